// File: rtl/sccb_arb.sv
// sccb_arb: arbitrates init-sequencer and runtime register writes
// onto a single SCCB master, with a watchdog on transaction completion.
module sccb_arb #(
   parameter int TIMEOUT_MAX = 20000,
   parameter bit USR_EARLY   = 1'b0
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        cfg_start,
   input  logic [23:0] cfg_data,
   input  logic        cfg_done,
   output logic        cfg_end,
   input  logic        usr_req,
   input  logic [23:0] usr_data,
   output logic        usr_ack,
   output logic        usr_end,
   output logic        i2c_start,
   output logic [23:0] i2c_data,
   input  logic        i2c_end,
   output logic        busy,
   output logic [1:0]  err
);

   localparam int CW = (TIMEOUT_MAX > 1) ? $clog2(TIMEOUT_MAX) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_MAX - 1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_WAIT = 1'b1;

   localparam logic OWN_CFG = 1'b0;
   localparam logic OWN_USR = 1'b1;

   logic [0:0]    state_q, state_d;
   logic          cfg_pend_q, cfg_pend_d;
   logic [23:0]   cfg_buf_q, cfg_buf_d;
   logic          owner_q, owner_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [23:0]   i2c_data_q, i2c_data_d;
   logic          i2c_start_q, i2c_start_d;
   logic          usr_ack_q, usr_ack_d;
   logic          cfg_end_q, cfg_end_d;
   logic          usr_end_q, usr_end_d;
   logic [1:0]    err_q, err_d;
   logic          usr_ok;

   assign usr_ok = cfg_done | USR_EARLY;

   // Next-state: grant in IDLE (cfg first), finish or time out in WAIT.
   always_comb begin
      state_d     = state_q;
      cfg_pend_d  = cfg_pend_q;
      cfg_buf_d   = cfg_buf_q;
      owner_d     = owner_q;
      cnt_d       = cnt_q;
      i2c_data_d  = i2c_data_q;
      i2c_start_d = 1'b0;
      usr_ack_d   = 1'b0;
      cfg_end_d   = 1'b0;
      usr_end_d   = 1'b0;
      err_d       = err_q;

      unique case (state_q)
         ST_IDLE: begin
            if (cfg_pend_q) begin
               i2c_data_d  = cfg_buf_q;
               i2c_start_d = 1'b1;
               cfg_pend_d  = 1'b0;
               owner_d     = OWN_CFG;
               cnt_d       = '0;
               state_d     = ST_WAIT;
            end else if (usr_req && usr_ok) begin
               i2c_data_d  = usr_data;
               i2c_start_d = 1'b1;
               usr_ack_d   = 1'b1;
               owner_d     = OWN_USR;
               cnt_d       = '0;
               state_d     = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (i2c_end || (cnt_q == CNT_LAST)) begin
               if (!i2c_end) begin
                  err_d[0] = 1'b1;
               end
               cfg_end_d = (owner_q == OWN_CFG);
               usr_end_d = (owner_q == OWN_USR);
               state_d   = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A new cfg word always wins the buffer; a second one before
      // the first is issued is flagged as an overrun.
      if (cfg_start) begin
         if (cfg_pend_q) begin
            err_d[1] = 1'b1;
         end
         cfg_pend_d = 1'b1;
         cfg_buf_d  = cfg_data;
      end
   end

   // State and output registers, cleared by async reset.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q     <= ST_IDLE;
         cfg_pend_q  <= 1'b0;
         cfg_buf_q   <= '0;
         owner_q     <= OWN_CFG;
         cnt_q       <= '0;
         i2c_data_q  <= '0;
         i2c_start_q <= 1'b0;
         usr_ack_q   <= 1'b0;
         cfg_end_q   <= 1'b0;
         usr_end_q   <= 1'b0;
         err_q       <= '0;
      end else begin
         state_q     <= state_d;
         cfg_pend_q  <= cfg_pend_d;
         cfg_buf_q   <= cfg_buf_d;
         owner_q     <= owner_d;
         cnt_q       <= cnt_d;
         i2c_data_q  <= i2c_data_d;
         i2c_start_q <= i2c_start_d;
         usr_ack_q   <= usr_ack_d;
         cfg_end_q   <= cfg_end_d;
         usr_end_q   <= usr_end_d;
         err_q       <= err_d;
      end
   end

   assign busy      = (state_q == ST_WAIT);
   assign i2c_start = i2c_start_q;
   assign i2c_data  = i2c_data_q;
   assign usr_ack   = usr_ack_q;
   assign cfg_end   = cfg_end_q;
   assign usr_end   = usr_end_q;
   assign err       = err_q;

endmodule

// File: tb/tb_sccb_arb.sv
// tb_sccb_arb: scoreboard bench for sccb_arb with an edge-timestamped
// reference model, directed scenarios and a randomized traffic phase.
module tb_sccb_arb;

   localparam int TMO   = 16;
   localparam bit EARLY = 1'b0;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        cfg_start = 1'b0;
   logic [23:0] cfg_data = '0;
   logic        cfg_done = 1'b0;
   logic        cfg_end;
   logic        usr_req = 1'b0;
   logic [23:0] usr_data = '0;
   logic        usr_ack;
   logic        usr_end;
   logic        i2c_start;
   logic [23:0] i2c_data;
   logic        i2c_end = 1'b0;
   logic        busy;
   logic [1:0]  err;

   sccb_arb #(.TIMEOUT_MAX(TMO), .USR_EARLY(EARLY)) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .cfg_start (cfg_start),
      .cfg_data  (cfg_data),
      .cfg_done  (cfg_done),
      .cfg_end   (cfg_end),
      .usr_req   (usr_req),
      .usr_data  (usr_data),
      .usr_ack   (usr_ack),
      .usr_end   (usr_end),
      .i2c_start (i2c_start),
      .i2c_data  (i2c_data),
      .i2c_end   (i2c_end),
      .busy      (busy),
      .err       (err)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      logic [23:0] d;
      logic        usr;
      int          e;
   } ev_t;

   ev_t sq[$];
   ev_t eq[$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // reference model state
   logic        m_busy = 1'b0;
   logic        m_own  = 1'b0;
   int          m_t0   = 0;
   logic        m_pend = 1'b0;
   logic [23:0] m_word = '0;
   logic [23:0] m_data = '0;
   logic [1:0]  m_err  = '0;

   // responder control: >=0 fixed latency, -1 silent, -2 random
   int resp_lat = 3;
   bit stray_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (edge %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic flag(input string nm, input logic [31:0] act);
      total++;
      bad++;
      $display("FAIL %s: got %h want none (edge %0d)", nm, act, cyc);
   endtask

   // Reference model: one step per sampled edge, events time-stamped.
   initial begin
      logic pend_was;
      forever begin
         @(posedge sys_clk or negedge sys_rst_n);
         if (!sys_rst_n) begin
            m_busy = 1'b0; m_own = 1'b0; m_pend = 1'b0;
            m_word = '0;   m_data = '0;  m_err = '0;
            sq.delete();   eq.delete();
         end else begin
            cyc++;
            pend_was = m_pend;
            if (!m_busy) begin
               if (m_pend) begin
                  sq.push_back('{d: m_word, usr: 1'b0, e: cyc});
                  m_data = m_word; m_own = 1'b0;
                  m_busy = 1'b1;   m_t0 = cyc; m_pend = 1'b0;
               end else if (usr_req && (cfg_done || EARLY)) begin
                  sq.push_back('{d: usr_data, usr: 1'b1, e: cyc});
                  m_data = usr_data; m_own = 1'b1;
                  m_busy = 1'b1;     m_t0 = cyc;
               end
            end else if (i2c_end || (cyc - m_t0 == TMO)) begin
               eq.push_back('{d: m_data, usr: m_own, e: cyc});
               if (!i2c_end) m_err[0] = 1'b1;
               m_busy = 1'b0;
            end
            if (cfg_start) begin
               if (pend_was) m_err[1] = 1'b1;
               m_pend = 1'b1;
               m_word = cfg_data;
            end
         end
      end
   end

   // Monitor: pops expected events when the DUT pulses outputs.
   initial begin
      ev_t ev;
      forever begin
         @(negedge sys_clk);
         if (sys_rst_n) begin
            if (i2c_start) begin
               if (sq.size() == 0) flag("start_spurious", 32'(i2c_data));
               else begin
                  ev = sq.pop_front();
                  chk("start_edge", cyc, ev.e);
                  chk("start_data", 32'(i2c_data), 32'(ev.d));
                  chk("start_ack", 32'(usr_ack), 32'(ev.usr));
               end
            end else if (usr_ack) flag("ack_alone", 32'(usr_ack));
            if (sq.size() > 0 && sq[0].e < cyc) begin
               ev = sq.pop_front();
               flag("start_missing", 32'(ev.d));
            end
            if (cfg_end || usr_end) begin
               if (eq.size() == 0) flag("end_spurious", {cfg_end, usr_end});
               else begin
                  ev = eq.pop_front();
                  chk("end_edge", cyc, ev.e);
                  chk("end_cfg", 32'(cfg_end), 32'(!ev.usr));
                  chk("end_usr", 32'(usr_end), 32'(ev.usr));
               end
            end
            if (eq.size() > 0 && eq[0].e < cyc) begin
               ev = eq.pop_front();
               flag("end_missing", 32'(ev.usr));
            end
            chk("err", 32'(err), 32'(m_err));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("i2c_data", 32'(i2c_data), 32'(m_data));
         end
      end
   end

   // SCCB master stand-in: answers each i2c_start after a latency.
   initial begin
      int cnt = -1;
      int lat;
      forever begin
         @(negedge sys_clk);
         i2c_end = 1'b0;
         if (i2c_start) begin
            lat = resp_lat;
            if (lat == -2) begin
               if ($urandom_range(0, 9) == 0) lat = -1;
               else lat = int'($urandom_range(0, 12));
            end
            cnt = lat;
         end
         if (cnt == 0) begin
            i2c_end = 1'b1;
            cnt = -1;
         end else if (cnt > 0) begin
            cnt--;
         end else if (stray_en && $urandom_range(0, 63) == 0) begin
            i2c_end = 1'b1;
         end
      end
   end

   initial begin
      repeat (90000) @(posedge sys_clk);
      $display("FAIL watchdog: got stuck want finish");
      $fatal(1, "bench watchdog expired");
   end

   task automatic cfg_pulse(input logic [23:0] d);
      @(negedge sys_clk);
      cfg_start = 1'b1;
      cfg_data  = d;
      @(negedge sys_clk);
      cfg_start = 1'b0;
   endtask

   task automatic usr_write(input logic [23:0] d, input int bound);
      @(negedge sys_clk);
      usr_req  = 1'b1;
      usr_data = d;
      for (int i = 0; i < bound; i++) begin
         @(negedge sys_clk);
         if (usr_ack) begin
            usr_req = 1'b0;
            return;
         end
      end
      usr_req = 1'b0;
      flag("usr_ack_timeout", 32'(d));
   endtask

   task automatic wait_end(input int bound);
      for (int i = 0; i < bound; i++) begin
         @(negedge sys_clk);
         if (cfg_end || usr_end) return;
      end
      flag("end_timeout", 32'(bound));
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_cfg_end"}, 32'(cfg_end), 0);
      chk({nm, "_usr_ack"}, 32'(usr_ack), 0);
      chk({nm, "_usr_end"}, 32'(usr_end), 0);
      chk({nm, "_i2c_start"}, 32'(i2c_start), 0);
      chk({nm, "_i2c_data"}, 32'(i2c_data), 0);
      chk({nm, "_busy"}, 32'(busy), 0);
      chk({nm, "_err"}, 32'(err), 0);
   endtask

   // Directed scenarios followed by randomized mixed traffic.
   initial begin
      bit seen;
      repeat (3) @(negedge sys_clk);
      chk_zero("reset");
      sys_rst_n = 1'b1;
      repeat (2) @(negedge sys_clk);

      // single cfg write with a 10-cycle transaction
      resp_lat = 10;
      cfg_pulse(24'h300882);
      wait_end(40);
      chk("cfg_end_busy", 32'(busy), 0);
      chk("cfg_end_data", 32'(i2c_data), 32'h300882);

      // cfg priority over a waiting user request
      cfg_done = 1'b1;
      cfg_pulse(24'h0a0b0c);
      repeat (2) @(negedge sys_clk);
      fork
         usr_write(24'h382047, 200);
         cfg_pulse(24'h0d0e0f);
      join
      chk("usr_after_cfg", 32'(i2c_data), 32'h382047);
      wait_end(40);
      chk("usr_end_seen", 32'(usr_end), 1);

      // user held off until cfg_done
      cfg_done = 1'b0;
      fork
         usr_write(24'h123456, 300);
         begin
            repeat (100) @(negedge sys_clk);
            cfg_done = 1'b1;
         end
      join
      wait_end(40);

      // watchdog timeout, then normal service resumes
      resp_lat = -1;
      cfg_pulse(24'habcdef);
      wait_end(60);
      chk("tmo_err", 32'(err), 32'h1);
      resp_lat = 3;
      cfg_pulse(24'h001122);
      wait_end(40);

      // cfg overrun while busy
      resp_lat = 10;
      cfg_pulse(24'h555555);
      repeat (2) @(negedge sys_clk);
      cfg_pulse(24'h310311);
      cfg_pulse(24'h310303);
      chk("ovr_err1", 32'(err[1]), 1);
      wait_end(40);
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge sys_clk);
         if (i2c_start) seen = 1'b1;
      end
      chk("ovr_seen", 32'(seen), 1);
      chk("ovr_data", 32'(i2c_data), 32'h310303);
      wait_end(40);

      // reset mid-transaction, late i2c_end must be ignored
      resp_lat = 10;
      cfg_pulse(24'h777777);
      repeat (3) @(negedge sys_clk);
      sys_rst_n = 1'b0;
      repeat (3) @(negedge sys_clk);
      chk_zero("midrst");
      sys_rst_n = 1'b1;
      repeat (15) @(negedge sys_clk);
      chk("midrst_busy", 32'(busy), 0);

      // randomized mixed traffic
      resp_lat = -2;
      stray_en = 1'b1;
      fork
         for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 40)) @(negedge sys_clk);
            cfg_pulse(24'($urandom));
         end
         for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 20)) @(negedge sys_clk);
            usr_write(24'($urandom), 2000);
         end
         for (int i = 0; i < 10; i++) begin
            cfg_done = 1'b0;
            repeat ($urandom_range(0, 30)) @(negedge sys_clk);
            cfg_done = 1'b1;
            repeat ($urandom_range(30, 150)) @(negedge sys_clk);
         end
      join

      stray_en = 1'b0;
      resp_lat = 3;
      repeat (80) @(negedge sys_clk);
      chk("start_q_drained", sq.size(), 0);
      chk("end_q_drained", eq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
